tt_um_ha_dk: RTL and testbench

//  Tiny Tapeout user tile built around a 4-lane half-adder array. Two 4-bit

---
 rtl/ha_dk_pkg.sv | 13 +
 rtl/ha_dk_cell.sv | 12 +
 rtl/tt_um_ha_dk.sv | 111 +++++++++++
 tb/tb_tt_um_ha_dk.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/ha_dk_pkg.sv
// Shared constants for the half-adder tile: mode encodings and lane count.
package ha_dk_pkg;

  localparam int LANES = 4;

  typedef enum logic [1:0] {
    MODE_BITWISE = 2'b00,
    MODE_CHAIN   = 2'b01,
    MODE_COUNT   = 2'b10,
    MODE_HOLD    = 2'b11
  } mode_e;

endpackage

// File: rtl/ha_dk_cell.sv
// Combinational 1-bit half adder: sum is XOR, carry is AND.
module ha_dk_cell (
  input  logic i_a,
  input  logic i_b,
  output logic o_s,
  output logic o_c
);

  assign o_s = i_a ^ i_b;
  assign o_c = i_a & i_b;

endmodule

// File: rtl/tt_um_ha_dk.sv
// Tiny Tapeout tile: 4-lane half-adder array with bitwise, chained-add and
// carry-count result modes. Define HADK_STATUS_EN to drive the status nibble on uio_out[7:4].
module tt_um_ha_dk
  import ha_dk_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [LANES-1:0] w_a;
  logic [LANES-1:0] w_b;
  logic [LANES-1:0] w_s;
  logic [LANES-1:0] w_c;
  logic [LANES-1:0] w_sum;
  logic [LANES-1:0] w_c2;
  logic [LANES:0]   w_cy;
  logic [4:0]       w_chain;
  mode_e            w_mode;
  logic             w_carry_any;
  logic [7:0]       w_cnt_next;
  logic             w_ovf_next;
  logic [7:0]       w_res;

  logic [7:0]       r_uo;
  logic [7:0]       r_cnt;
  logic             r_ovf;

  assign w_a    = ui_in[3:0];
  assign w_b    = ui_in[7:4];
  assign w_mode = mode_e'(uio_in[1:0]);

  // Each lane's first cell is the bitwise half adder; a second cell folds in
  // the incoming ripple carry, making a full adder from two half adders.
  assign w_cy[0] = 1'b0;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    ha_dk_cell u_lane (
      .i_a (w_a[i]),
      .i_b (w_b[i]),
      .o_s (w_s[i]),
      .o_c (w_c[i])
    );
    ha_dk_cell u_chain (
      .i_a (w_s[i]),
      .i_b (w_cy[i]),
      .o_s (w_sum[i]),
      .o_c (w_c2[i])
    );
    assign w_cy[i+1] = w_c[i] | w_c2[i];
  end

  assign w_chain     = {w_cy[LANES], w_sum};
  assign w_carry_any = |w_c;
  assign w_cnt_next  = r_cnt + {7'd0, w_carry_any};
  assign w_ovf_next  = r_ovf | (w_carry_any & (r_cnt == 8'hFF));

  // COUNT presents the post-edge count so the reading edge itself is included.
  always_comb begin
    w_res = r_uo;
    case (w_mode)
      MODE_BITWISE: w_res = {w_c, w_s};
      MODE_CHAIN:   w_res = {3'b000, w_chain};
      MODE_COUNT:   w_res = w_cnt_next;
      MODE_HOLD:    w_res = r_uo;
      default:      w_res = r_uo;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_uo  <= 8'h00;
      r_cnt <= 8'h00;
      r_ovf <= 1'b0;
    end else if (ena) begin
      r_uo  <= w_res;
      r_cnt <= w_cnt_next;
      r_ovf <= w_ovf_next;
    end
  end

  assign uo_out = r_uo;

`ifdef HADK_STATUS_EN
  logic [3:0] r_stat;
  logic       w_unused_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat <= 4'h0;
    end else if (ena) begin
      r_stat <= {w_ovf_next, w_carry_any, ^w_s, w_cy[LANES]};
    end
  end

  assign uio_out     = {r_stat, 4'h0};
  assign uio_oe      = 8'hF0;
  assign w_unused_ok = &{1'b0, uio_in[7:2]};
`else
  logic w_unused_ok;

  assign uio_out     = 8'h00;
  assign uio_oe      = 8'h00;
  assign w_unused_ok = &{1'b0, uio_in[7:2], r_ovf};
`endif

endmodule

// File: tb/tb_tt_um_ha_dk.sv
// Directed bench for tt_um_ha_dk: reset, each mode, counter wrap, hold/enable
// and asynchronous reset, with hand-computed expected values.
module tb_tt_um_ha_dk;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int total;
  int bad;

`ifdef HADK_STATUS_EN
  localparam logic [7:0] OE_EXP    = 8'hF0;
  localparam logic [7:0] ST_6A_EXP = 8'h50;
  localparam logic [7:0] ST_FF_EXP = 8'h50;
  localparam logic [7:0] ST_0_EXP  = 8'h00;
  localparam logic [7:0] ST_OV_EXP = 8'h80;
`else
  localparam logic [7:0] OE_EXP    = 8'h00;
  localparam logic [7:0] ST_6A_EXP = 8'h00;
  localparam logic [7:0] ST_FF_EXP = 8'h00;
  localparam logic [7:0] ST_0_EXP  = 8'h00;
  localparam logic [7:0] ST_OV_EXP = 8'h00;
`endif

  tt_um_ha_dk dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;

    #12;
    chk("reset_uo", uo_out, 8'h00);
    chk("reset_oe", uio_oe, OE_EXP);
    chk("reset_uio", uio_out, 8'h00);
    rst_n = 1'b1;
    uio_in = 8'h02;
    step();
    chk("reset_cnt", uo_out, 8'h00);

    // BITWISE and CHAIN
    ui_in = 8'h6A; uio_in = 8'h00;
    step();
    chk("bitwise_6A", uo_out, 8'h2C);
    chk("status_6A", uio_out, ST_6A_EXP);
    uio_in = 8'h01;
    step();
    chk("chain_6A", uo_out, 8'h10);
    ui_in = 8'hFF;
    step();
    chk("chain_FF", uo_out, 8'h1E);
    chk("status_FF", uio_out, ST_FF_EXP);
    ui_in = 8'h0F;
    step();
    chk("chain_0F", uo_out, 8'h0F);

    // COUNT: five carry edges, sixth edge reads and counts too
    pulse_reset();
    ui_in = 8'h6A; uio_in = 8'h00;
    for (int i = 0; i < 5; i++) step();
    uio_in = 8'h02;
    step();
    chk("count_6", uo_out, 8'h06);
    ui_in = 8'h00;
    step();
    chk("count_zero_ops", uo_out, 8'h06);
    ui_in = 8'h0F;
    step();
    chk("count_no_carry", uo_out, 8'h06);

    // HOLD with carry-free operands
    ui_in = 8'h6A; uio_in = 8'h00;
    step();
    chk("hold_pre", uo_out, 8'h2C);
    uio_in = 8'h03; ui_in = 8'h0F;
    step();
    chk("hold_a", uo_out, 8'h2C);
    ui_in = 8'hF0;
    step();
    chk("hold_b", uo_out, 8'h2C);
    uio_in = 8'h02; ui_in = 8'h00;
    step();
    chk("hold_cnt", uo_out, 8'h07);

    // ena=0 freezes everything even with carrying inputs
    ui_in = 8'h6A; uio_in = 8'h00;
    step();
    chk("ena_pre", uo_out, 8'h2C);
    ena = 1'b0; ui_in = 8'hFF; uio_in = 8'h01;
    step();
    chk("ena_off_chain", uo_out, 8'h2C);
    uio_in = 8'h02;
    step();
    chk("ena_off_count", uo_out, 8'h2C);
    ena = 1'b1; ui_in = 8'h00;
    step();
    chk("ena_cnt", uo_out, 8'h08);

    // Counter wrap and sticky overflow
    pulse_reset();
    ui_in = 8'hFF; uio_in = 8'h00;
    for (int i = 0; i < 255; i++) step();
    chk("wrap_bitwise", uo_out, 8'hF0);
    ui_in = 8'h00; uio_in = 8'h02;
    step();
    chk("wrap_cnt_FF", uo_out, 8'hFF);
    chk("wrap_status_pre", uio_out, ST_0_EXP);
    ui_in = 8'hFF; uio_in = 8'h00;
    step();
    ui_in = 8'h00; uio_in = 8'h02;
    step();
    chk("wrap_cnt_00", uo_out, 8'h00);
    chk("wrap_ovf", uio_out, ST_OV_EXP);
    step();
    chk("wrap_ovf_sticky", uio_out, ST_OV_EXP);

    // Asynchronous reset between edges
    ui_in = 8'h6A; uio_in = 8'h00;
    step();
    chk("midrst_pre", uo_out, 8'h2C);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_uo", uo_out, 8'h00);
    chk("midrst_uio", uio_out, 8'h00);
    rst_n = 1'b1;
    ui_in = 8'h00; uio_in = 8'h02;
    step();
    chk("midrst_cnt", uo_out, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
